// File: rtl/ascon_input_loader_pkg.sv
// Shared definitions for the ASCON input loader.
//   state_t     : loader FSM states
//   ISEL_*      : register-file bus select codes
//   WORD_W      : stream / register-file bus width
//   is_hdr_state: true in the four key/nonce word states
package ascon_pkg;

  localparam int WORD_W = 64;

  typedef enum logic [2:0] {
    IDLE,
    KEY_HI,
    KEY_LO,
    NONCE_HI,
    NONCE_LO,
    WAIT_INIT,
    BLOCKS,
    DONE
  } state_t;

  localparam logic [1:0] ISEL_KEY   = 2'd0;
  localparam logic [1:0] ISEL_NONCE = 2'd1;
  localparam logic [1:0] ISEL_BLOCK = 2'd2;

  function automatic logic is_hdr_state(input state_t s);
    return (s == KEY_HI) || (s == KEY_LO) || (s == NONCE_HI) || (s == NONCE_LO);
  endfunction

endpackage

// File: rtl/ascon_input_loader_if.sv
// 64-bit valid/ready word stream feeding the ASCON input loader.
//   s_data  : stream word
//   s_valid : word valid
//   s_last  : marks the final data block
//   s_ready : loader can accept the word
// master = producer side, slave = loader side.
interface ascon_input_loader_if;
  import ascon_pkg::*;

  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;

  modport master (output s_data, s_valid, s_last, input s_ready);
  modport slave  (input s_data, s_valid, s_last, output s_ready);
endinterface

// File: rtl/ascon_input_loader.sv
// ASCON input loader: sequences a word stream (key hi, key lo, nonce hi,
// nonce lo, then data blocks) into the input register file, and releases
// key/nonce and each block to the permutation core on its request.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   start                 : begin a transaction (only honoured in IDLE)
//   s (slave)             : input word stream
//   core_init_req         : core takes key+nonce (only honoured in WAIT_INIT)
//   core_blk_req          : core wants the next data block
//   DataI, Isel           : register-file data bus and target select
//   Key*/Nonce*/Block*    : register-file enables, half selects, load strobes
//   init_rdy              : key and nonce staged, awaiting core_init_req
//   last_blk              : last block transferred carried s_last
//   blk_count             : data blocks accepted this transaction (wraps)
//   busy, done            : not idle / one-cycle end-of-transaction pulse
module ascon_input_loader
  import ascon_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  ascon_input_loader_if.slave  s,
  input  logic                 core_init_req,
  input  logic                 core_blk_req,
  output logic [WORD_W-1:0]    DataI,
  output logic [1:0]           Isel,
  output logic                 Keyen,
  output logic                 Keysel,
  output logic                 Keyload,
  output logic                 Nonceen,
  output logic                 Noncesel,
  output logic                 Nonceload,
  output logic                 Blocken,
  output logic                 Blocksel,
  output logic                 Blockload,
  output logic                 init_rdy,
  output logic                 last_blk,
  output logic [CNT_W-1:0]     blk_count,
  output logic                 busy,
  output logic                 done
);

  state_t state, state_nx;

  // One-deep block staging: a block sits in the register file (staged_full)
  // until the core has asked for it (req_pend), then both are consumed.
  logic staged_full, staged_last, req_pend;
  logic rdy, accept, xfer;

  always_comb begin
    rdy = 1'b0;
    if (is_hdr_state(state))  rdy = 1'b1;
    else if (state == BLOCKS) rdy = !staged_full;
  end

  assign s.s_ready = rdy;
  assign accept    = s.s_valid & rdy;
  assign xfer      = (state == BLOCKS) & req_pend & staged_full;

  assign init_rdy  = (state == WAIT_INIT);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign Blocksel  = 1'b0;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (start)         state_nx = KEY_HI;
      KEY_HI:    if (accept)        state_nx = KEY_LO;
      KEY_LO:    if (accept)        state_nx = NONCE_HI;
      NONCE_HI:  if (accept)        state_nx = NONCE_LO;
      NONCE_LO:  if (accept)        state_nx = WAIT_INIT;
      WAIT_INIT: if (core_init_req) state_nx = BLOCKS;
      BLOCKS:    if (xfer && staged_last) state_nx = DONE;
      DONE:                         state_nx = IDLE;
      default:                      state_nx = IDLE;
    endcase
  end

  // Register-file bus, strobes and block-staging flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      DataI       <= '0;
      Isel        <= ISEL_KEY;
      Keyen       <= 1'b0;
      Keysel      <= 1'b0;
      Keyload     <= 1'b0;
      Nonceen     <= 1'b0;
      Noncesel    <= 1'b0;
      Nonceload   <= 1'b0;
      Blocken     <= 1'b0;
      Blockload   <= 1'b0;
      staged_full <= 1'b0;
      staged_last <= 1'b0;
      req_pend    <= 1'b0;
      last_blk    <= 1'b0;
      blk_count   <= '0;
    end else begin
      // enables and load strobes are single-cycle pulses
      Keyen     <= 1'b0;
      Nonceen   <= 1'b0;
      Blocken   <= 1'b0;
      Keyload   <= 1'b0;
      Nonceload <= 1'b0;
      Blockload <= 1'b0;

      if (state == IDLE && start) begin
        blk_count   <= '0;
        last_blk    <= 1'b0;
        staged_full <= 1'b0;
        staged_last <= 1'b0;
        req_pend    <= 1'b0;
      end

      if (accept) begin
        DataI <= s.s_data;
        unique case (state)
          KEY_HI:   begin Isel <= ISEL_KEY;   Keyen   <= 1'b1; Keysel   <= 1'b0; end
          KEY_LO:   begin Isel <= ISEL_KEY;   Keyen   <= 1'b1; Keysel   <= 1'b1; end
          NONCE_HI: begin Isel <= ISEL_NONCE; Nonceen <= 1'b1; Noncesel <= 1'b0; end
          NONCE_LO: begin Isel <= ISEL_NONCE; Nonceen <= 1'b1; Noncesel <= 1'b1; end
          BLOCKS: begin
            Isel        <= ISEL_BLOCK;
            Blocken     <= 1'b1;
            staged_full <= 1'b1;
            staged_last <= s.s_last;
            blk_count   <= blk_count + CNT_W'(1);
          end
          default: ;
        endcase
      end

      if (state == WAIT_INIT && core_init_req) begin
        Keyload   <= 1'b1;
        Nonceload <= 1'b1;
      end

      if (state == BLOCKS && core_blk_req) req_pend <= 1'b1;

      // A request arriving on the transfer edge belongs to the block being
      // transferred and is absorbed: the clear below wins over the set above.
      if (xfer) begin
        Blockload   <= 1'b1;
        staged_full <= 1'b0;
        req_pend    <= 1'b0;
        last_blk    <= staged_last;
      end
    end
  end

endmodule

// File: tb/tb_ascon_input_loader.sv
module tb_ascon_input_loader;
  import ascon_pkg::*;

  localparam int CNT_W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, core_init_req = 1'b0, core_blk_req = 1'b0;
  logic [63:0] DataI;
  logic [1:0]  Isel;
  logic Keyen, Keysel, Keyload, Nonceen, Noncesel, Nonceload;
  logic Blocken, Blocksel, Blockload, init_rdy, last_blk, busy, done;
  logic [CNT_W-1:0] blk_count;

  ascon_input_loader_if sif();

  ascon_input_loader #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s(sif),
    .core_init_req(core_init_req), .core_blk_req(core_blk_req),
    .DataI(DataI), .Isel(Isel),
    .Keyen(Keyen), .Keysel(Keysel), .Keyload(Keyload),
    .Nonceen(Nonceen), .Noncesel(Noncesel), .Nonceload(Nonceload),
    .Blocken(Blocken), .Blocksel(Blocksel), .Blockload(Blockload),
    .init_rdy(init_rdy), .last_blk(last_blk), .blk_count(blk_count),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    total++;
    bad++;
    $display("FAIL %s: got strobe expected none", name);
  endtask

  // expectations, pushed by stimulus and consumed by the monitor
  logic [255:0] exp_init_q[$];   // {key_hi, key_lo, nonce_hi, nonce_lo}
  logic [64:0]  exp_blk_q[$];    // {last, data}
  int           exp_done_q[$];   // blocks in the transaction

  // Behavioural register file: what the downstream file would capture
  logic [127:0] rf_key, rf_nonce;
  logic [63:0]  rf_blk;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_key <= '0; rf_nonce <= '0; rf_blk <= '0;
    end else begin
      if (Keyen)   begin if (Keysel)   rf_key[63:0]   <= DataI; else rf_key[127:64]   <= DataI; end
      if (Nonceen) begin if (Noncesel) rf_nonce[63:0] <= DataI; else rf_nonce[127:64] <= DataI; end
      if (Blocken) rf_blk <= DataI;
    end
  end

  // Monitor: sampled on the falling edge
  bit staged = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) staged = 1'b0;
    else begin
      if (Keyen || Nonceen || Blocken) begin
        chk("one_enable", 256'(int'(Keyen) + int'(Nonceen) + int'(Blocken)), 256'(1));
        chk("isel", 256'(Isel), Keyen ? 256'(0) : Nonceen ? 256'(1) : 256'(2));
      end
      if (Blockload) begin
        chk("blkload_after_blken", 256'(staged), 256'(1));
        staged = 1'b0;
        if (exp_blk_q.size() == 0) miss("unexpected_blockload");
        else begin
          logic [64:0] e;
          e = exp_blk_q.pop_front();
          chk("block_data", 256'(rf_blk), 256'(e[63:0]));
          chk("last_blk", 256'(last_blk), 256'(e[64]));
        end
      end
      if (Blocken) begin
        chk("blken_while_staged", 256'(staged), 256'(0));
        staged = 1'b1;
      end else if (staged) chk("sready_while_staged", 256'(sif.s_ready), 256'(0));
      if (Keyload || Nonceload) begin
        chk("init_pair", 256'({Keyload, Nonceload}), 256'(2'b11));
        if (exp_init_q.size() == 0) miss("unexpected_init_load");
        else begin
          logic [255:0] e;
          e = exp_init_q.pop_front();
          chk("key", 256'(rf_key), 256'(e[255:128]));
          chk("nonce", 256'(rf_nonce), 256'(e[127:0]));
        end
      end
      if (done) begin
        if (exp_done_q.size() == 0) miss("unexpected_done");
        else begin
          int n;
          n = exp_done_q.pop_front();
          chk("done_count", 256'(blk_count), 256'(n % (1 << CNT_W)));
          chk("done_busy", 256'(busy), 256'(1));
        end
      end
    end
  end

  function automatic bit pick(input int sel);
    case (sel)
      0: return init_rdy;
      1: return Keyload;
      2: return Blockload;
      default: return !busy;
    endcase
  endfunction

  // bounded wait; returns just after a falling edge
  task automatic wait_for(input int sel, input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!pick(sel) && n < 400);
    if (!pick(sel)) begin
      total++; bad++;
      $display("FAIL timeout_%s: got no event expected one within 400 cycles", name);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // entered and left at posedge+1
  task automatic send(input logic [63:0] d, input bit last, input bit inj_start, input bit inj_init);
    int n = 0;
    sif.s_data = d; sif.s_valid = 1'b1; sif.s_last = last;
    start = inj_start; core_init_req = inj_init;
    do begin @(negedge clk); n++; end while (!sif.s_ready && n < 400);
    if (!sif.s_ready) begin
      total++; bad++;
      $display("FAIL timeout_send: got s_ready=0 expected 1 within 400 cycles");
    end
    @(posedge clk); #1;
    sif.s_valid = 1'b0; sif.s_last = $urandom_range(0, 1);
    sif.s_data = {$urandom, $urandom};   // must be ignored while not accepted
    start = 1'b0; core_init_req = 1'b0;
  endtask

  task automatic pulse_req(input bit hold2);
    core_blk_req = 1'b1; tick(1);
    if (hold2) tick(1);
    core_blk_req = 1'b0;
  endtask

  task automatic header(input int mode);
    logic [63:0] w[4];
    for (int i = 0; i < 4; i++) w[i] = (mode == 1) ? 64'(i + 1) : {$urandom, $urandom};
    exp_init_q.push_back({w[0], w[1], w[2], w[3]});
    start = 1'b1; tick(1); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick($urandom_range(0, 2));
      send(w[i], (mode == 2) && i < 2, (mode == 2) && i == 2, (mode == 2) && i == 1);
    end
    wait_for(0, "init_rdy");
    @(posedge clk); #1;
    tick($urandom_range(0, 3));
    core_init_req = 1'b1; tick(1); core_init_req = 1'b0;
    wait_for(1, "keyload");
    @(posedge clk); #1;
  endtask

  // mode 0 random, 1 nominal, 2 ignored-control injection
  // rgap/fgap < 0 means random request/feed gaps
  task automatic run_txn(input int mode, input int nblk, input int rgap, input int fgap, input bit hold2);
    logic [63:0] blks[$];
    chk("idle_before_start", 256'(busy), 256'(0));
    header(mode);
    for (int j = 0; j < nblk; j++) begin
      blks.push_back((mode == 1) ? 64'hAAAA : {$urandom, $urandom});
      exp_blk_q.push_back({(j == nblk - 1), blks[j]});
    end
    exp_done_q.push_back(nblk);
    fork
      begin
        for (int j = 0; j < nblk; j++) begin
          tick(fgap < 0 ? $urandom_range(0, 3) : fgap);
          send(blks[j], j == nblk - 1, 1'b0, 1'b0);
        end
      end
      begin
        for (int j = 0; j < nblk; j++) begin
          tick(rgap < 0 ? $urandom_range(0, 6) : rgap);
          pulse_req(hold2);
          wait_for(2, "blockload");
          @(posedge clk); #1;
        end
      end
    join
    wait_for(3, "idle");
    @(posedge clk); #1;
  endtask

  task automatic chk_zero(input string name);
    chk(name, 256'({DataI, Isel, Keyen, Keysel, Keyload, Nonceen, Noncesel, Nonceload,
                    Blocken, Blocksel, Blockload, init_rdy, last_blk, blk_count, busy, done,
                    sif.s_ready}), 256'(0));
  endtask

  initial begin
    sif.s_valid = 1'b0; sif.s_data = '0; sif.s_last = 1'b0;
    tick(3);
    chk_zero("reset_state");
    rst_n = 1'b1;
    tick(2);

    // nominal: key {1,2}, nonce {3,4}, one last block 0xAAAA
    run_txn(1, 1, 2, 0, 1'b0);
    chk("nominal_count_hold", 256'(blk_count), 256'(1));
    chk("nominal_last_hold", 256'(last_blk), 256'(1));

    // backpressure: three blocks, core requests 10 cycles apart
    run_txn(0, 3, 10, 0, 1'b0);

    // early request (held two cycles) before each block arrives
    run_txn(0, 2, 0, 6, 1'b1);

    // ignored start / core_init_req / s_last on header words
    run_txn(2, 2, -1, -1, 1'b0);

    // reset with a block staged
    header(0);
    send({$urandom, $urandom}, 1'b0, 1'b0, 1'b0);
    tick(2);
    rst_n = 1'b0;
    #1;
    chk_zero("reset_mid_block");
    tick(3);
    rst_n = 1'b1;
    tick(20);
    chk("after_reset_idle", 256'(busy), 256'(0));

    // five blocks, 2-bit counter wraps to 1
    run_txn(0, 5, -1, -1, 1'b0);
    chk("wrap_count_hold", 256'(blk_count), 256'(1));

    for (int t = 0; t < 6; t++) run_txn(0, $urandom_range(1, 6), -1, -1, 1'b0);

    tick(5);
    chk("queues_drained", 256'(exp_init_q.size() + exp_blk_q.size() + exp_done_q.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end expected finish before 1ms");
    $fatal(1, "watchdog");
  end

endmodule
